alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 159 +++++++++++++++
 tb/tb_alu_issue.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_issue
// Description : Command FIFO feeding an external combinational ALU, with a
//               registered result held under consumer backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_oc,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    output logic [2:0] alu_oc,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [3:0] alu_f,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_f,
    output logic       res_err,
    output logic [7:0] done_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   c_depth   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_cnt_one = (AW+1)'(1);
    localparam logic [AW-1:0] c_ptr_one = AW'(1);
    localparam logic [2:0]    c_oc_div  = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [10:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [2:0]    r_oc;
    logic [3:0]    r_a;
    logic [3:0]    r_b;
    logic [3:0]    r_res_f;
    logic          r_res_err;
    logic          r_res_valid;
    logic [7:0]    r_done;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic          w_div0;

    // in_ready depends only on the occupancy register, never on res_ready
    assign in_ready = (r_count < c_depth);
    assign w_empty  = (r_count == '0);
    assign w_push   = in_valid && in_ready;
    assign w_pop    = !w_empty &&
                      ((r_state == S_IDLE) || ((r_state == S_HOLD) && res_ready));
    assign w_div0   = (r_oc == c_oc_div) && (r_b == 4'd0);

    assign alu_oc    = r_oc;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign res_f     = r_res_f;
    assign res_err   = r_res_err;
    assign res_valid = r_res_valid;
    assign done_cnt  = r_done;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {in_oc, in_a, in_b};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_next = S_HOLD;
            end
            S_HOLD: begin
                if (res_ready) begin
                    w_next = w_empty ? S_IDLE : S_EXEC;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_oc        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_res_f     <= '0;
            r_res_err   <= 1'b0;
            r_res_valid <= 1'b0;
            r_done      <= '0;
        end else begin
            r_state <= w_next;
            if (w_pop) begin
                {r_oc, r_a, r_b} <= r_mem[r_rptr];
            end
            case (r_state)
                S_EXEC: begin
                    // Divide by zero overrides whatever the ALU produced
                    r_res_f     <= w_div0 ? 4'hF : alu_f;
                    r_res_err   <= w_div0;
                    r_res_valid <= 1'b1;
                end
                S_HOLD: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_done      <= r_done + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue
// Description : Directed self-checking bench for alu_issue with a reference ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_oc = '0;
    logic [3:0] in_a = '0;
    logic [3:0] in_b = '0;
    logic [2:0] alu_oc;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_f;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [3:0] res_f;
    logic       res_err;
    logic [7:0] done_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [2:0] s_oc [8];
    logic [3:0] s_a  [8];
    logic [3:0] s_b  [8];
    logic [3:0] s_f  [8];

    alu_issue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_oc(in_oc), .in_a(in_a), .in_b(in_b),
        .alu_oc(alu_oc), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_f(res_f), .res_err(res_err), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU; divide by zero returns 3 so an unmasked result is visible
    always_comb begin
        alu_f = 4'h0;
        case (alu_oc)
            3'b000: alu_f = alu_a + alu_b;
            3'b001: alu_f = alu_a - alu_b;
            3'b010: alu_f = alu_a * alu_b;
            3'b011: alu_f = (alu_b == 4'd0) ? 4'h3 : alu_a / alu_b;
            3'b100: alu_f = ~alu_a;
            3'b101: alu_f = alu_a ^ alu_b;
            3'b110: alu_f = alu_a | alu_b;
            default: alu_f = alu_a & alu_b;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] oc, input logic [3:0] a, input logic [3:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            in_valid = 1'b0;
            n++;
            @(negedge clk);
        end
        if (n == 50) check("drive_ready", in_ready, 1);
        in_valid = 1'b1;
        in_oc = oc;
        in_a = a;
        in_b = b;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [3:0] ef, input logic ee, output int at);
        int n;
        n = 0;
        @(negedge clk);
        while (!res_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_valid"}, res_valid, 1);
        check({tag, "_f"}, res_f, ef);
        check({tag, "_err"}, res_err, ee);
        at = cyc;
    endtask

    task automatic run_stream(input int n, input bit from_table, input bit gap_check);
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    if (from_table) drive(s_oc[i], s_a[i], s_b[i]);
                    else drive(3'b000, 4'(i), 4'd1);
                end
                idle();
            end
            begin
                int prev;
                int at;
                logic [3:0] ef;
                prev = 0;
                for (int j = 0; j < n; j++) begin
                    if (from_table) ef = s_f[j];
                    else ef = 4'(j + 1);
                    wait_result("stream", ef, 1'b0, at);
                    if (gap_check && j > 0) check("stream_gap", at - prev, 2);
                    prev = at;
                end
            end
        join
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int at;
        int seen;
        s_oc = '{3'b000, 3'b110, 3'b011, 3'b001, 3'b010, 3'b111, 3'b100, 3'b101};
        s_a  = '{4'h1, 4'h5, 4'h7, 4'h0, 4'h4, 4'hF, 4'h0, 4'hA};
        s_b  = '{4'h2, 4'h8, 4'h2, 4'h1, 4'h4, 4'h3, 4'h0, 4'h5};
        s_f  = '{4'h3, 4'hD, 4'h3, 4'hF, 4'h0, 4'h3, 4'hF, 4'hF};

        // Reset state
        #1;
        check("rst_res_valid", res_valid, 0);
        check("rst_done_cnt", done_cnt, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_res_f", res_f, 0);
        check("rst_res_err", res_err, 0);
        check("rst_alu_ops", {alu_oc, alu_a, alu_b}, 0);
        @(negedge clk);
        rst = 1'b0;
        res_ready = 1'b1;

        // Single ADD with latency check
        drive(3'b000, 4'd3, 4'd4);
        idle();
        check("add_lat0_valid", res_valid, 0);
        @(negedge clk);
        check("add_alu_ops", {alu_oc, alu_a, alu_b}, {3'b000, 4'd3, 4'd4});
        check("add_lat1_valid", res_valid, 0);
        @(negedge clk);
        check("add_lat2_valid", res_valid, 1);
        check("add_f", res_f, 7);
        check("add_err", res_err, 0);
        @(negedge clk);
        check("add_done_cnt", done_cnt, 1);
        check("add_valid_clear", res_valid, 0);

        // Divide by zero, then a normal divide
        drive(3'b011, 4'd9, 4'd0);
        idle();
        wait_result("div0", 4'hF, 1'b1, at);
        drive(3'b011, 4'd9, 4'd2);
        idle();
        wait_result("div", 4'h4, 1'b0, at);
        @(negedge clk);
        check("div_done_cnt", done_cnt, 3);

        // Backpressure: one in HOLD, four queued, then a push attempt while full
        res_ready = 1'b0;
        drive(3'b010, 4'd3, 4'd5);
        drive(3'b001, 4'd2, 4'd5);
        drive(3'b100, 4'd5, 4'd0);
        drive(3'b101, 4'd6, 4'd3);
        drive(3'b111, 4'hC, 4'hA);
        @(negedge clk);
        in_oc = 3'b000; in_a = 4'd1; in_b = 4'd1;
        check("full_in_ready", in_ready, 0);
        check("full_hold_f", res_f, 4'hF);
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        check("full_in_ready_late", in_ready, 0);
        check("full_hold_valid", res_valid, 1);
        check("full_hold_f_stable", res_f, 4'hF);
        check("full_hold_err", res_err, 0);
        res_ready = 1'b1;
        wait_result("bp_sub", 4'hD, 1'b0, at);
        wait_result("bp_not", 4'hA, 1'b0, at);
        wait_result("bp_xor", 4'h5, 1'b0, at);
        wait_result("bp_and", 4'h8, 1'b0, at);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        check("bp_no_extra", seen, 0);
        check("bp_done_cnt", done_cnt, 8);
        check("bp_in_ready", in_ready, 1);

        // Continuous stream, one result every two cycles
        run_stream(8, 1'b1, 1'b1);
        @(negedge clk);
        check("stream_done_cnt", done_cnt, 16);

        // Counter wrap
        run_stream(239, 1'b0, 1'b0);
        @(negedge clk);
        check("wrap_255", done_cnt, 255);
        run_stream(1, 1'b0, 1'b0);
        @(negedge clk);
        check("wrap_0", done_cnt, 0);

        // Reset while holding a result with two commands queued
        drive(3'b000, 4'd1, 4'd1);
        idle();
        wait_result("pre_rst", 4'h2, 1'b0, at);
        @(negedge clk);
        check("pre_rst_done", done_cnt, 1);
        res_ready = 1'b0;
        drive(3'b110, 4'd1, 4'd2);
        drive(3'b110, 4'd4, 4'd2);
        drive(3'b110, 4'd8, 4'd2);
        idle();
        check("pre_rst_hold", res_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", res_valid, 0);
        check("async_rst_done", done_cnt, 0);
        check("async_rst_in_ready", in_ready, 1);
        check("async_rst_alu_a", alu_a, 0);
        @(negedge clk);
        rst = 1'b0;
        res_ready = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        check("post_rst_no_result", seen, 0);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_done", done_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
